// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flop iterated over WIDTH clocks,
// with a start/busy/done handshake. Define SERIAL_ADDER_SUB_EN to add the `sub` port (A-B mode).
module serial_adder #(
  parameter int WIDTH = 2
) (
  input  logic             CLKIN,
  input  logic             RESETN,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] O,
  output logic             COUT
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d, o_q, o_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, busy_q, busy_d, done_q, done_d, cout_q, cout_d;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld, accept, s;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as A + ~B + 1; COUT=1 then means no borrow.
  assign b_ld = sub ? ~B : B;
  assign c_ld = sub | CIN;
`else
  assign b_ld = B;
  assign c_ld = CIN;
`endif

  // busy_q stays high through the cycle done is shown, so that edge cannot re-accept.
  assign accept = (state_q == IDLE) && start && !busy_q;
  assign s      = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_sr_d  = A;
          b_sr_d  = b_ld;
          carry_d = c_ld;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        carry_d           = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
        res_d             = res_q >> 1;
        res_d[WIDTH-1]    = s;
        a_sr_d            = a_sr_q >> 1;
        b_sr_d            = b_sr_q >> 1;
        cnt_d             = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered one stage behind the FSM.
  always_comb begin
    done_d = (state_q == DONE);
    o_d    = (state_q == DONE) ? res_q : o_q;
    cout_d = (state_q == DONE) ? carry_q : cout_q;
    busy_d = (state_d != IDLE) || (state_q == DONE);
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      o_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      o_q     <= o_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign O    = o_q;
  assign COUT = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder (WIDTH=2), plus hand-written multi-cycle
// sequences; subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  localparam int W = 2;

  logic         CLKIN = 1'b0;
  logic         RESETN = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         CIN = 1'b0;
  logic         busy, done, COUT;
  logic [W-1:0] O;
  logic         sub = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLKIN = ~CLKIN;

  serial_adder #(.WIDTH(W)) dut (
    .CLKIN(CLKIN), .RESETN(RESETN), .start(start), .A(A), .B(B), .CIN(CIN),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .O(O), .COUT(COUT)
  );

`ifdef SERIAL_ADDER_SUB_EN
  logic       start8 = 1'b0;
  logic [7:0] A8 = '0, B8 = '0, O8;
  logic       busy8, done8, COUT8;
  serial_adder #(.WIDTH(8)) dut8 (
    .CLKIN(CLKIN), .RESETN(RESETN), .start(start8), .A(A8), .B(B8), .CIN(1'b0),
    .sub(1'b1), .busy(busy8), .done(done8), .O(O8), .COUT(COUT8)
  );
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sb;
    logic [W-1:0] o;
    logic         cout;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One full operation: accept edge, then checks done timing, result and busy release.
  task automatic do_op(input vec_t v, input string name);
    @(negedge CLKIN);
    A = v.a; B = v.b; CIN = v.cin; sub = v.sb; start = 1'b1;
    @(posedge CLKIN); #1;
    start = 1'b0;
    check({name, " busy@accept"}, busy, 1);
    for (int n = 1; n <= W + 2; n++) begin
      @(posedge CLKIN); #1;
      if (n == W + 1) begin
        check({name, " done"}, done, 1);
        check({name, " busy@done"}, busy, 1);
        check({name, " O"}, O, v.o);
        check({name, " COUT"}, COUT, v.cout);
      end else begin
        check({name, " no_done"}, done, 0);
      end
      if (n == W + 2) check({name, " busy_release"}, busy, 0);
    end
  endtask

  vec_t tbl[8];

  initial begin
    int dcnt, blow;
    tbl[0] = '{2'd3, 2'd1, 1'b0, 1'b0, 2'b00, 1'b1};
    tbl[1] = '{2'd2, 2'd1, 1'b0, 1'b0, 2'b11, 1'b0};
    tbl[2] = '{2'd3, 2'd3, 1'b1, 1'b0, 2'b11, 1'b1};
    tbl[3] = '{2'd0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[4] = '{2'd1, 2'd1, 1'b1, 1'b0, 2'b11, 1'b0};
    tbl[5] = '{2'd3, 2'd3, 1'b0, 1'b0, 2'b10, 1'b1};
    tbl[6] = '{2'd2, 2'd2, 1'b1, 1'b0, 2'b01, 1'b1};
    tbl[7] = '{2'd0, 2'd3, 1'b1, 1'b0, 2'b00, 1'b1};

    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset O", O, 0);
    check("reset COUT", COUT, 0);
    @(negedge CLKIN); RESETN = 1'b1;

    foreach (tbl[i]) do_op(tbl[i], $sformatf("vec%0d", i));

    // Last result (0+3+1 = 4 -> 00, carry 1) must hold while idle.
    repeat (3) @(posedge CLKIN);
    #1;
    check("hold O", O, 0);
    check("hold COUT", COUT, 1);
    check("hold busy", busy, 0);

    // start held high: accepts every W+3 edges, one idle cycle between operations.
    @(negedge CLKIN);
    A = 2'd1; B = 2'd1; CIN = 1'b0; start = 1'b1;
    dcnt = 0; blow = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge CLKIN); #1;
      if (i == 11) start = 1'b0;
      if (done) begin
        dcnt++;
        check("b2b O", O, 2);
        check("b2b COUT", COUT, 0);
      end
      if (i <= 12 && !busy) blow++;
    end
    check("b2b done count", dcnt, 3);
    check("b2b idle gaps", blow, 2);

    // start during SHIFT is ignored; in-flight 1+2 is still reported.
    @(negedge CLKIN);
    A = 2'd1; B = 2'd2; CIN = 1'b0; start = 1'b1;
    @(posedge CLKIN); #1;
    start = 1'b0;
    @(negedge CLKIN);
    A = 2'd3; B = 2'd3; CIN = 1'b1; start = 1'b1;
    @(posedge CLKIN); #1;
    start = 1'b0;
    @(posedge CLKIN); #1;
    @(posedge CLKIN); #1;
    check("ign done", done, 1);
    check("ign O", O, 3);
    check("ign COUT", COUT, 0);
    @(posedge CLKIN); #1;
    check("ign not_queued1", busy, 0);
    @(posedge CLKIN); #1;
    check("ign not_queued2", busy, 0);

    // Async reset one cycle after accept aborts the operation.
    @(negedge CLKIN);
    A = 2'd3; B = 2'd3; CIN = 1'b0; start = 1'b1;
    @(posedge CLKIN); #1;
    start = 1'b0;
    @(posedge CLKIN); #2;
    RESETN = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort O", O, 0);
    check("abort COUT", COUT, 0);
    @(negedge CLKIN); RESETN = 1'b1;
    do_op('{2'd0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0}, "post_reset");

`ifdef SERIAL_ADDER_SUB_EN
    do_op('{2'd1, 2'd2, 1'b0, 1'b1, 2'b11, 1'b0}, "sub 1-2");
    do_op('{2'd2, 2'd1, 1'b0, 1'b1, 2'b01, 1'b1}, "sub 2-1");
    @(negedge CLKIN);
    A8 = 8'h80; B8 = 8'h01; start8 = 1'b1;
    @(posedge CLKIN); #1;
    start8 = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20 && !done8; i++) begin
      @(posedge CLKIN); #1;
      dcnt++;
    end
    check("sub8 latency", dcnt, 9);
    check("sub8 O", O8, 8'h7F);
    check("sub8 COUT", COUT8, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
